piso_serializer: RTL
====================

// Module: piso_serializer
// PURPOSE
//  Parallel-in/serial-out stage that consumes bytes from the parallel shift_reg data path.
//  - Accepts one WIDTH-bit word per valid/ready handshake.
//  - Shifts the word out one bit at a time; each bit is held for DIV clock cycles.
//  - Issues a one-cycle done pulse per word. Sits between the parallel data path and a serial link or pin.
// PARAMETERS
//  WIDTH      8  bits per word; legal range >= 2
//  DIV        4  clock cycles each bit is held on ser_o; legal range >= 1
//  MSB_FIRST  0  0: bit 0 is sent first; 1: bit WIDTH-1 is sent first
// PORTS
//  clk_i         in   1      single clock, rising edge
//  reset_i       in   1      synchronous, active-high reset
//  din_i         in   WIDTH  parallel word to send
//  din_valid_i   in   1      din_i is valid
//  din_ready_o   out  1      block can accept a word this cycle
//  ser_o         out  1      serial data bit
//  ser_valid_o   out  1      ser_o carries a valid bit
//  bit_strobe_o  out  1      one-cycle pulse on the first cycle of each bit
//  done_o        out  1      one-cycle pulse after the last bit of a word
//  busy_o        out  1      a word is being shifted
// BEHAVIOUR
//  - All outputs are registered. reset_i is sampled on clk_i and overrides all other inputs.
//  - Reset values: din_ready_o=1; ser_o, ser_valid_o, bit_strobe_o, done_o, busy_o = 0; state=IDLE.
//  - FSM states: IDLE and SHIFT.
//  - IDLE:
//    - din_ready_o=1.
//    - A word is accepted on an edge where din_valid_i && din_ready_o.
//    - On acceptance, din_i is latched into the internal shift register and the FSM moves to SHIFT.
//  - SHIFT:
//    - din_ready_o=0, busy_o=1, ser_valid_o=1.
//    - din_valid_i is ignored; the word on din_i is not consumed.
//  - Timing, word accepted at edge N:
//    - Bit k (k=0..WIDTH-1) drives ser_o during cycles N+1+k*DIV through N+(k+1)*DIV.
//    - bit_strobe_o=1 in cycle N+1+k*DIV only.
//    - Bit order: bit k is din[k] when MSB_FIRST=0, din[WIDTH-1-k] when MSB_FIRST=1.
//    - Cycle N+WIDTH*DIV+1 (first cycle back in IDLE): done_o=1, din_ready_o=1, busy_o=0, ser_valid_o=0.
//    - ser_o holds the last bit value in IDLE. Receivers qualify ser_o with ser_valid_o.
//  - Counters:
//    - Divider counter, $clog2(DIV) bits (minimum 1 bit), counts 0..DIV-1 and wraps to 0.
//    - Bit counter, $clog2(WIDTH) bits, increments when the divider wraps.
//    - The word ends when the bit counter is WIDTH-1 and the divider is DIV-1. Neither counter overflows.
//  - DIV=1: one bit per cycle; bit_strobe_o is high on every SHIFT cycle.
//  - Back-to-back words:
//    - A word may be accepted in the same cycle done_o is high.
//    - Its first bit appears on the next cycle.
//    - Minimum gap between words is one IDLE cycle.
//  - Reset mid-operation:
//    - The next edge with reset_i=1 aborts the word.
//    - No done_o is generated and all outputs take their reset values.
//    - The partial word is discarded.
//  - done_o and bit_strobe_o are never high in the same cycle.
//  - busy_o is exactly the inverse of din_ready_o.
// TESTING
//  1. Reset: hold reset_i for 3 cycles -> din_ready_o=1; all other outputs 0; done_o never pulses.
//  2. WIDTH=8, DIV=4, MSB_FIRST=0, send 0xA5 at edge N:
//     -> ser_o = 1,0,1,0,0,1,0,1, each bit held 4 cycles from N+1.
//     -> 8 bit_strobe_o pulses; done_o in cycle N+33.
//  3. MSB_FIRST=1, DIV=1, send 0x80:
//     -> ser_o = 1,0,0,0,0,0,0,0 on cycles N+1..N+8; done_o in cycle N+9.
//  4. din_valid_i held high with 0x3C and then 0xFF while busy:
//     -> 0xFF is accepted only in the done_o cycle.
//     -> 0x3C is sent intact, followed by 0xFF with a one-cycle gap.
//  5. Assert reset_i during bit 3 of 0x5A:
//     -> outputs take reset values on the next edge; no done_o.
//     -> a following 0x01 is sent correctly.
//  6. DIV=1, 4 words streamed with din_valid_i held high:
//     -> each word takes 9 cycles (8 bits + 1 IDLE); 4 done_o pulses, 9 cycles apart.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: takes one WIDTH-bit word per valid/ready handshake
// and shifts it out one bit at a time, each bit held for DIV clock cycles.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter int DIV       = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             din_valid_i,
  output logic             din_ready_o,
  output logic             ser_o,
  output logic             ser_valid_o,
  output logic             bit_strobe_o,
  output logic             done_o,
  output logic             busy_o
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = $clog2(WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             ser_q, ser_d;
  logic             ser_valid_q, ser_valid_d;
  logic             strobe_q, strobe_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  // Head bit and remaining-bits word, for both a fresh word and the shift register.
  logic             head_din, head_sreg;
  logic [WIDTH-1:0] rest_din, rest_sreg;

  always_comb begin
    if (MSB_FIRST != 0) begin
      head_din  = din_i[WIDTH-1];
      head_sreg = sreg_q[WIDTH-1];
      rest_din  = {din_i[WIDTH-2:0], 1'b0};
      rest_sreg = {sreg_q[WIDTH-2:0], 1'b0};
    end else begin
      head_din  = din_i[0];
      head_sreg = sreg_q[0];
      rest_din  = {1'b0, din_i[WIDTH-1:1]};
      rest_sreg = {1'b0, sreg_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    div_cnt_d   = div_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    ser_d       = ser_q;
    ser_valid_d = ser_valid_q;
    strobe_d    = 1'b0;
    done_d      = 1'b0;
    ready_d     = ready_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        ready_d     = 1'b1;
        busy_d      = 1'b0;
        ser_valid_d = 1'b0;
        if (din_valid_i && ready_q) begin
          state_d     = SHIFT;
          ser_d       = head_din;
          sreg_d      = rest_din;
          div_cnt_d   = '0;
          bit_cnt_d   = '0;
          strobe_d    = 1'b1;
          ser_valid_d = 1'b1;
          busy_d      = 1'b1;
          ready_d     = 1'b0;
        end
      end
      SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          if (bit_cnt_q == BIT_LAST) begin
            // ser_o keeps the last bit; receivers qualify it with ser_valid_o.
            state_d     = IDLE;
            done_d      = 1'b1;
            ready_d     = 1'b1;
            busy_d      = 1'b0;
            ser_valid_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            div_cnt_d = '0;
            ser_d     = head_sreg;
            sreg_d    = rest_sreg;
            strobe_d  = 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      ser_q       <= 1'b0;
      ser_valid_q <= 1'b0;
      strobe_q    <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      ser_q       <= ser_d;
      ser_valid_q <= ser_valid_d;
      strobe_q    <= strobe_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign din_ready_o  = ready_q;
  assign ser_o        = ser_q;
  assign ser_valid_o  = ser_valid_q;
  assign bit_strobe_o = strobe_q;
  assign done_o       = done_q;
  assign busy_o       = busy_q;

endmodule
